alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the single-cycle 16-bit processor ALU. It supports the same eight operations at a configurable datapath width and lane size, and adds registered operands and results with a valid/ready handshake and backpressure. A flag register (N, Z, V) is updated per operation class. It sits in the EX stage of the processor and can also serve as a standalone execution unit with stall-capable consumers.

## Interface
- WIDTH, 16: datapath width; a multiple of 8, at least 16.
- LANE, 4: PADDSB lane width; must divide WIDTH.
- SATURATE, 1: 1 means ADD/SUB saturate to signed max/min on overflow; 0 means wrap.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid & in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift and rotate amount is b[$clog2(WIDTH)-1:0].
- op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB; 1xxx is illegal.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- result  out  WIDTH  registered result.
- flags  out  3  {N,Z,V} flag register.
- illegal  out  1  qualified by out_valid; the result came from a 1xxx opcode.

## Operation
- Stage S1 registers a, b and op on input handshake. Stage S2 computes and registers result, illegal and the flag update.
- ADD/SUB: a ± b at WIDTH bits.
  - V is signed overflow.
  - If SATURATE=1, an overflowing result clamps to 0111…1 (positive overflow) or 1000…0 (negative overflow).
  - N = result MSB after saturation. Z = (result == 0).
- XOR: a ^ b.
- RED: sign-extended sum of all signed bytes of a and all signed bytes of b. Computed at full precision, then truncated or sign-extended to WIDTH.
- SLL: logical left shift. SRA: arithmetic right shift. ROR: rotate right. All use amount = b[$clog2(WIDTH)-1:0].
- PADDSB: independent LANE-bit signed saturating add per lane. Saturated lanes clamp to the lane max or min; there is no carry between lanes.
- Flag update on S2 capture:
  - ADD/SUB update N, Z and V.
  - XOR, SLL, SRA and ROR update Z only.
  - RED, PADDSB and illegal opcodes leave all flags unchanged.
- Illegal opcode: result = 0, illegal = 1, flags unchanged.

## Timing
- Reset (rst_n low, asynchronous):
  - S1 and S2 valid bits cleared, so out_valid = 0.
  - result = 0, flags = 000, illegal = 0.
  - in_ready = 1 one cycle after deassertion. Reset mid-operation discards all in-flight work.
- Latency: 2 cycles from input handshake to out_valid with no stall.
- Throughput: one operation per cycle while out_ready = 1.
- S2 loads when S2 is empty or drained this cycle (out_valid & out_ready).
- S1 loads when S1 is empty or advancing into S2 this cycle.
- in_ready = !S1_valid | S1_advance. in_ready is combinational from out_ready and is the only combinational path.
- Full: with out_ready held 0, at most 2 operations are buffered. in_ready then drops, and out_valid and result stay stable until accepted.
- Simultaneous accept and drain: the new input and the S1→S2 move both happen with no bubble.
- flush: clears both valid bits at the next edge and blocks flag updates that cycle.
  - An input handshake in the same cycle as flush is dropped.
  - flush has priority over every other event.
- Flags change only on the cycle S2 captures a flag-updating operation. They are visible with that operation's out_valid.

## Test plan
- Reset with in-flight ops, WIDTH=16: assert rst_n low mid-stream -> out_valid=0 immediately; flags=000; first op after release ADD 0x0001+0x0001 -> result 0x0002, flags 000 two cycles later.
- Saturation, SATURATE=1: ADD 0x7FFF+0x0001 -> 0x7FFF, V=1, N=0. SUB 0x8000-0x0001 -> 0x8000, V=1, N=1. SATURATE=0, ADD 0x7FFF+0x0001 -> 0x8000, V=1.
- Flag classes: SUB 5-5 -> Z=1. Then SLL 0x0001 by 1 -> 0x0002, Z=0, N and V retain prior values. Then PADDSB -> flags unchanged.
- PADDSB and RED: PADDSB 0x7777+0x1111 -> 0x7777 (lanes saturate). 0x1234+0x1111 -> 0x2345. RED a=0x0102, b=0xFF01 -> 0x0003.
- Backpressure: stream 5 ADDs with out_ready toggling 1,0,0,1,… -> results in order, none lost or duplicated; in_ready low only when 2 operations are buffered.
- flush and illegal: issue 2 ops, then flush -> no output for either; then op 1010 -> illegal=1, result 0, flags unchanged. Also ROR 0x8001 by 1 at WIDTH=32 -> 0x80004000.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and N/Z/V flags.
// Ports: clk, rst_n, flush, in_valid/in_ready, a, b, op, out_valid/out_ready, result, flags, illegal.
module alu_pipe #(
  parameter int WIDTH    = 16,
  parameter int LANE     = 4,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             illegal
);
  localparam int M  = WIDTH - 1;
  localparam int SH = $clog2(WIDTH);
  localparam int NB = WIDTH / 8;
  localparam int NL = WIDTH / LANE;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  logic             rdy_q;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;
  logic             s2_load;
  logic             s1_adv;
  logic             in_fire;

  // rdy_q holds in_ready low until the first edge after reset release.
  assign s2_load  = !out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_load;
  assign in_ready = rdy_q & (!s1_valid | s1_adv);
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_fire) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  function automatic logic [WIDTH+7:0] sx8(input logic [7:0] x);
    return {{WIDTH{x[7]}}, x};
  endfunction

  // Overflow direction follows the sign of a for both add and subtract.
  function automatic logic [WIDTH-1:0] sat(
    input logic [WIDTH-1:0] r,
    input logic             ov,
    input logic             neg
  );
    if (SATURATE != 0 && ov) return neg ? SMIN : SMAX;
    return r;
  endfunction

  logic [SH-1:0]      amt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   dif;
  logic               ov_add;
  logic               ov_sub;
  logic [WIDTH+7:0]   red;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   padd;
  logic [LANE-1:0]    la;
  logic [LANE-1:0]    lb;
  logic [LANE-1:0]    ls;
  logic [WIDTH-1:0]   res_c;
  logic [2:0]         flg_c;
  logic               ill_c;

  assign amt = s1_b[SH-1:0];

  always_comb begin
    sum    = s1_a + s1_b;
    dif    = s1_a - s1_b;
    ov_add = (s1_a[M] == s1_b[M]) & (sum[M] != s1_a[M]);
    ov_sub = (s1_a[M] != s1_b[M]) & (dif[M] != s1_a[M]);
    rot    = {s1_a, s1_a} >> amt;
    red    = '0;
    for (int i = 0; i < NB; i++) begin
      red = red + sx8(s1_a[i*8 +: 8]) + sx8(s1_b[i*8 +: 8]);
    end
    padd = '0;
    la   = '0;
    lb   = '0;
    ls   = '0;
    for (int i = 0; i < NL; i++) begin
      la = s1_a[i*LANE +: LANE];
      lb = s1_b[i*LANE +: LANE];
      ls = la + lb;
      if (la[LANE-1] == lb[LANE-1] && ls[LANE-1] != la[LANE-1]) begin
        ls = la[LANE-1] ? LMIN : LMAX;
      end
      padd[i*LANE +: LANE] = ls;
    end
  end

  always_comb begin
    res_c = '0;
    flg_c = flags;
    ill_c = 1'b0;
    unique case (s1_op)
      4'b0000: begin
        res_c = sat(sum, ov_add, s1_a[M]);
        flg_c = {res_c[M], res_c == '0, ov_add};
      end
      4'b0001: begin
        res_c = sat(dif, ov_sub, s1_a[M]);
        flg_c = {res_c[M], res_c == '0, ov_sub};
      end
      4'b0010: begin
        res_c    = s1_a ^ s1_b;
        flg_c[1] = res_c == '0;
      end
      4'b0011: res_c = red[WIDTH-1:0];
      4'b0100: begin
        res_c    = s1_a << amt;
        flg_c[1] = res_c == '0;
      end
      4'b0101: begin
        res_c    = $signed(s1_a) >>> amt;
        flg_c[1] = res_c == '0;
      end
      4'b0110: begin
        res_c    = rot[WIDTH-1:0];
        flg_c[1] = res_c == '0;
      end
      4'b0111: res_c = padd;
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_c;
        flags   <= flg_c;
        illegal <= ill_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: three instances (16-bit saturating,
// 16-bit wrapping, 32-bit) driven with directed vectors.
module tb_alu_pipe;
  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    logic        i;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush0 = 0, in_valid0 = 0, out_ready0 = 1;
  logic        in_ready0, out_valid0, illegal0;
  logic [15:0] a0 = 0, b0 = 0, result0;
  logic [3:0]  op0 = 0;
  logic [2:0]  flags0;

  logic        flush1 = 0, in_valid1 = 0, out_ready1 = 1;
  logic        in_ready1, out_valid1, illegal1;
  logic [15:0] a1 = 0, b1 = 0, result1;
  logic [3:0]  op1 = 0;
  logic [2:0]  flags1;

  logic        flush2 = 0, in_valid2 = 0, out_ready2 = 1;
  logic        in_ready2, out_valid2, illegal2;
  logic [31:0] a2 = 0, b2 = 0, result2;
  logic [3:0]  op2 = 0;
  logic [2:0]  flags2;

  alu_pipe #(.WIDTH(16), .LANE(4), .SATURATE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .op(op0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .flags(flags0), .illegal(illegal0));

  alu_pipe #(.WIDTH(16), .LANE(4), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .flags(flags1), .illegal(illegal1));

  alu_pipe #(.WIDTH(32), .LANE(4), .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .flags(flags2), .illegal(illegal2));

  int   nchk = 0;
  int   nfail = 0;
  bit   bp_chk = 0;
  bit   bp_done = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic exp_t mk(logic [31:0] r, logic [2:0] f, logic i);
    exp_t e;
    e.r = r;
    e.f = f;
    e.i = i;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    nchk++;
    nfail++;
    $display("FAIL %s actual=timeout required=progress", nm);
  endtask

  exp_t e0, e1, e2;

  always @(negedge clk) begin
    if (rst_n && bp_chk) begin
      cmp("bp_in_ready", {31'b0, in_ready0},
          {31'b0, !(q0.size() == 2 && !out_ready0)});
    end
    if (rst_n && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL u0_unexpected actual=%h required=none", result0);
      end else begin
        e0 = q0.pop_front();
        cmp("u0_result", {16'b0, result0}, e0.r);
        cmp("u0_flags", {29'b0, flags0}, {29'b0, e0.f});
        cmp("u0_illegal", {31'b0, illegal0}, {31'b0, e0.i});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL u1_unexpected actual=%h required=none", result1);
      end else begin
        e1 = q1.pop_front();
        cmp("u1_result", {16'b0, result1}, e1.r);
        cmp("u1_flags", {29'b0, flags1}, {29'b0, e1.f});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL u2_unexpected actual=%h required=none", result2);
      end else begin
        e2 = q2.pop_front();
        cmp("u2_result", result2, e2.r);
        cmp("u2_flags", {29'b0, flags2}, {29'b0, e2.f});
      end
    end
  end

  task automatic send0(input logic [15:0] ta, input logic [15:0] tb,
                       input logic [3:0] top, input logic [15:0] er,
                       input logic [2:0] ef, input logic ei,
                       input bit push);
    int n;
    n = 0;
    a0 = ta;
    b0 = tb;
    op0 = top;
    in_valid0 = 1'b1;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) begin
      miss("u0_send");
      in_valid0 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    if (push) q0.push_back(mk({16'b0, er}, ef, ei));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) miss(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    cmp("rst_out_valid", {31'b0, out_valid0}, 0);
    cmp("rst_flags", {29'b0, flags0}, 0);
    cmp("rst_result", {16'b0, result0}, 0);
    cmp("rst_in_ready_low", {31'b0, in_ready0}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a0 = 16'h4000;
    b0 = 16'h4000;
    op0 = 4'b0000;
    in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    a0 = 16'h7FFF;
    b0 = 16'h0001;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    cmp("inflight_valid", {31'b0, out_valid0}, 1);
    cmp("inflight_flags", {29'b0, flags0}, 32'h1);
    rst_n = 1'b0;
    #1;
    cmp("midrst_out_valid", {31'b0, out_valid0}, 0);
    cmp("midrst_flags", {29'b0, flags0}, 0);
    cmp("midrst_result", {16'b0, result0}, 0);
    cmp("midrst_illegal", {31'b0, illegal0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp("rel_in_ready_low", {31'b0, in_ready0}, 0);
    @(posedge clk);
    #1;
    cmp("rel_in_ready_high", {31'b0, in_ready0}, 1);

    send0(16'h0001, 16'h0001, 4'b0000, 16'h0002, 3'b000, 0, 1);
    cmp("lat_not_yet", {31'b0, out_valid0}, 0);
    @(posedge clk);
    #1;
    cmp("lat_two", {31'b0, out_valid0}, 1);
    cmp("lat_result", {16'b0, result0}, 32'h2);

    send0(16'h7FFF, 16'h0001, 4'b0000, 16'h7FFF, 3'b001, 0, 1);
    send0(16'h8000, 16'h0001, 4'b0001, 16'h8000, 3'b101, 0, 1);
    send0(16'h0005, 16'h0005, 4'b0010, 16'h0000, 3'b111, 0, 1);
    send0(16'h7777, 16'h1111, 4'b0111, 16'h7777, 3'b111, 0, 1);
    send0(16'h1234, 16'h1111, 4'b0111, 16'h2345, 3'b111, 0, 1);
    send0(16'h0102, 16'hFF01, 4'b0011, 16'h0003, 3'b111, 0, 1);
    send0(16'h8000, 16'h0004, 4'b0101, 16'hF800, 3'b101, 0, 1);
    send0(16'h0001, 16'h0001, 4'b0110, 16'h8000, 3'b101, 0, 1);
    send0(16'h0005, 16'h0005, 4'b0001, 16'h0000, 3'b010, 0, 1);
    send0(16'h0001, 16'h0001, 4'b0100, 16'h0002, 3'b000, 0, 1);
    send0(16'h1234, 16'h1111, 4'b0111, 16'h2345, 3'b000, 0, 1);
    drain("drain_basic");

    out_ready0 = 1'b0;
    send0(16'h0003, 16'h0004, 4'b0000, 16'h0007, 3'b000, 0, 1);
    send0(16'h0002, 16'h0003, 4'b0001, 16'hFFFF, 3'b100, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("full_in_ready", {31'b0, in_ready0}, 0);
      cmp("full_valid", {31'b0, out_valid0}, 1);
      cmp("full_result", {16'b0, result0}, 32'h7);
    end
    @(posedge clk);
    #1;
    out_ready0 = 1'b1;
    drain("drain_full");

    bp_chk = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          send0(16'(i * 256), 16'h0001, 4'b0000,
                16'(i * 256 + 1), 3'b000, 0, 1);
        end
        drain("drain_bp");
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready0 = (k % 4 == 0) || (k % 4 == 3);
          k++;
        end
      end
    join
    bp_chk = 1'b0;
    out_ready0 = 1'b1;

    send0(16'h8000, 16'h0001, 4'b0001, 16'h8000, 3'b101, 0, 1);
    drain("drain_pre_flush");
    send0(16'h0000, 16'h0000, 4'b0000, 16'h0000, 3'b010, 0, 0);
    a0 = 16'h0001;
    b0 = 16'h0001;
    op0 = 4'b0000;
    in_valid0 = 1'b1;
    flush0 = 1'b1;
    @(posedge clk);
    #1;
    flush0 = 1'b0;
    in_valid0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("flush_no_out", {31'b0, out_valid0}, 0);
      cmp("flush_flags", {29'b0, flags0}, 32'h5);
    end
    @(posedge clk);
    #1;
    send0(16'h1234, 16'h0001, 4'b1010, 16'h0000, 3'b101, 1, 1);
    drain("drain_illegal");

    a1 = 16'h7FFF;
    b1 = 16'h0001;
    op1 = 4'b0000;
    in_valid1 = 1'b1;
    a2 = 32'h0000_8001;
    b2 = 32'h0000_0001;
    op2 = 4'b0110;
    in_valid2 = 1'b1;
    @(negedge clk);
    cmp("u1_in_ready", {31'b0, in_ready1}, 1);
    cmp("u2_in_ready", {31'b0, in_ready2}, 1);
    @(posedge clk);
    #1;
    q1.push_back(mk(32'h0000_8000, 3'b101, 0));
    q2.push_back(mk(32'h8000_4000, 3'b000, 0));
    in_valid1 = 1'b0;
    a2 = 32'h0102_0304;
    b2 = 32'hFFFF_FFFF;
    op2 = 4'b0011;
    @(negedge clk);
    cmp("u2_in_ready_b2b", {31'b0, in_ready2}, 1);
    @(posedge clk);
    #1;
    q2.push_back(mk(32'h0000_0006, 3'b000, 0));
    in_valid2 = 1'b0;
    drain("drain_wide");

    repeat (3) @(posedge clk);
    cmp("q_left", q0.size() + q1.size() + q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
